// File: rtl/truth_table_scanner.sv
// rtl/truth_table_scanner.sv - steps every input code through a combinational
// function block and captures its truth table and ones count.
module truth_table_scanner #(
    parameter int N_IN   = 5,
    parameter int SETTLE = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   f_in,
    output logic [N_IN-1:0]        code_out,
    output logic                   busy,
    output logic                   done,
    output logic [(1<<N_IN)-1:0]   table_out,
    output logic [N_IN:0]          ones_count
);

    localparam logic [3:0]      SETTLE_MAX = 4'(SETTLE);
    localparam logic [N_IN-1:0] LAST_CODE  = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [3:0]             r_settle;
    logic [N_IN-1:0]        r_code;
    logic [(1<<N_IN)-1:0]   r_table;
    logic [N_IN:0]          r_ones;
    logic                   w_sample;
    logic                   w_last;

    // f_in is only trusted on the final cycle of each code's hold window.
    assign w_sample = (r_state == S_DRIVE) && (r_settle == SETTLE_MAX);
    assign w_last   = w_sample && (r_code == LAST_CODE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_DRIVE;
            S_DRIVE: if (w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_settle <= '0;
            r_code   <= '0;
            r_table  <= '0;
            r_ones   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_settle <= '0;
                        r_code   <= '0;
                        r_table  <= '0;
                        r_ones   <= '0;
                    end
                end
                S_DRIVE: begin
                    if (w_sample) begin
                        r_table[r_code] <= f_in;
                        if (f_in) begin
                            r_ones <= r_ones + (N_IN+1)'(1);
                        end
                        r_settle <= '0;
                        // Leaving DRIVE parks the code at 0 rather than wrapping it.
                        if (w_last) begin
                            r_code <= '0;
                        end else begin
                            r_code <= r_code + N_IN'(1);
                        end
                    end else begin
                        r_settle <= r_settle + 4'd1;
                    end
                end
                default: begin
                    r_code <= '0;
                end
            endcase
        end
    end

    assign code_out   = r_code;
    assign busy       = (r_state == S_DRIVE);
    assign done       = (r_state == S_DONE);
    assign table_out  = r_table;
    assign ones_count = r_ones;

endmodule
